// File: rtl/ula_pkg.sv
// ula_pkg: shared encodings and defaults for the ULA datapath blocks
package ula_pkg;
    localparam logic SOMA    = 1'b0;
    localparam logic SUBTRAI = 1'b1;
    localparam int LARGURA_PADRAO = 8;
    typedef enum logic {OCIOSO = 1'b0, CALCULA = 1'b1} estado_t;
endpackage

// File: rtl/somador_completo.sv
// somador_completo: single-bit full adder cell
module somador_completo (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/somador_digito.sv
// somador_digito: combinational DIGITO-bit ripple slice, also exposing the
// carry into its top bit so the caller can derive signed overflow
module somador_digito #(
    parameter int DIGITO = 1
) (
    input  logic [DIGITO-1:0] a,
    input  logic [DIGITO-1:0] b,
    input  logic              cin,
    output logic [DIGITO-1:0] s,
    output logic              cout,
    output logic              c_topo
);
    logic [DIGITO:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < DIGITO; i++) begin : g_bit
        somador_completo u_fa (
            .a(a[i]),
            .b(b[i]),
            .cin(c[i]),
            .s(s[i]),
            .cout(c[i+1])
        );
    end
    assign cout   = c[DIGITO];
    assign c_topo = c[DIGITO-1];
endmodule

// File: rtl/somador_subtrator_serial.sv
// somador_subtrator_serial: digit-serial adder/subtractor with start/done
// handshake, subtract mode and signed-overflow flag
module somador_subtrator_serial
    import ula_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int DIGITO  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inicio,
    input  logic               modo,
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    output logic               ocupado,
    output logic               pronto,
    output logic [LARGURA:0]   s,
    output logic               estouro
);
    localparam int P  = LARGURA / DIGITO;
    localparam int CW = $clog2(P + 1);

    if (LARGURA < 2 || DIGITO < 1 || LARGURA % DIGITO != 0) begin : g_param_invalido
        $error("LARGURA must be >= 2 and a multiple of DIGITO");
    end

    estado_t            estado;
    logic [CW-1:0]      cont;
    logic [LARGURA-1:0] op_a, op_b, res, res_prox;
    logic               carry, cout, c_topo, ultimo;
    logic [DIGITO-1:0]  soma;

    somador_digito #(.DIGITO(DIGITO)) u_digito (
        .a(op_a[DIGITO-1:0]),
        .b(op_b[DIGITO-1:0]),
        .cin(carry),
        .s(soma),
        .cout(cout),
        .c_topo(c_topo)
    );

    // new sum digit enters at the top; after P steps the LSB digit has reached bit 0
    assign res_prox = LARGURA'({soma, res} >> DIGITO);
    assign ultimo   = cont == CW'(P - 1);
    assign ocupado  = estado == CALCULA;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            estado  <= OCIOSO;
            cont    <= '0;
            op_a    <= '0;
            op_b    <= '0;
            res     <= '0;
            carry   <= 1'b0;
            pronto  <= 1'b0;
            s       <= '0;
            estouro <= 1'b0;
        end else begin
            pronto <= 1'b0;
            if (estado == OCIOSO && inicio) begin
                op_a   <= a;
                op_b   <= b ^ {LARGURA{modo}};
                carry  <= modo == SUBTRAI;
                cont   <= '0;
                estado <= CALCULA;
            end else if (estado == CALCULA) begin
                op_a  <= op_a >> DIGITO;
                op_b  <= op_b >> DIGITO;
                res   <= res_prox;
                carry <= cout;
                cont  <= cont + CW'(1);
                if (ultimo) begin
                    s       <= {cout, res_prox};
                    estouro <= c_topo ^ cout;
                    pronto  <= 1'b1;
                    estado  <= OCIOSO;
                end
            end
        end
endmodule
